// File: rtl/ipr_arb_pkg.sv
// ipr_arb_pkg
// Shared types for the IPR read/write arbiter.
//   ipr_port_e                   : identifies the requesting port (read or write)
//   IPR_MAX_OUTSTANDING_DEFAULT  : default depth of the in-flight ID FIFO
//   other_port()                 : returns the port that is not the argument

package ipr_arb_pkg;

    typedef enum logic {
        PORT_RD = 1'b0,
        PORT_WR = 1'b1
    } ipr_port_e;

    localparam int unsigned IPR_MAX_OUTSTANDING_DEFAULT = 4;

    function automatic ipr_port_e other_port(input ipr_port_e p);
        return (p == PORT_RD) ? PORT_WR : PORT_RD;
    endfunction

endpackage

// File: rtl/ipr_id_fifo.sv
// ipr_id_fifo
// In-order FIFO of port IDs, one entry per accepted-but-unanswered memory
// transaction. The head tells the arbiter which port owns the next response.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, push_id     : enqueue push_id (ignored when full)
//   pop               : dequeue the head (ignored when empty)
//   head              : registered head entry (valid when !empty)
//   full, empty, cnt  : occupancy status, all derived from registered state

module ipr_id_fifo
    import ipr_arb_pkg::*;
#(
    parameter int unsigned DEPTH = IPR_MAX_OUTSTANDING_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  ipr_port_e     push_id,
    input  logic          pop,
    output ipr_port_e     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] cnt
);

    ipr_port_e     mem_q [DEPTH];
    ipr_port_e     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;
    assign head  = mem_q[rd_ptr_q];

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= PORT_RD;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/ipr_rw_arbiter.sv
// ipr_rw_arbiter
// Shares one OBI-style memory slave port between the IPR read port and the
// IPR write port. Round-robin arbitration, with a lock that holds an offered
// but ungranted request on the bus until it is granted. Responses are routed
// back in order using an ID FIFO.
// Ports:
//   clk, rst                                   : clock, synchronous active-high reset
//   rd_req/rd_addr/rd_be/rd_we                 : read-port request (rd_we ignored)
//   rd_gnt/rd_rvalid/rd_rdata                  : read-port grant and response
//   wr_req/wr_addr/wr_wdata/wr_be/wr_we        : write-port request (wr_we ignored)
//   wr_gnt/wr_rvalid/wr_rdata                  : write-port grant and response
//   mem_req/mem_addr/mem_wdata/mem_we/mem_be   : downstream request
//   mem_gnt/mem_rvalid/mem_rdata               : downstream grant and response
//   err                                        : pulse on a response with nothing outstanding
//
// Handshake: a transfer is accepted in the cycle where req and gnt are both
// high. Once req is raised it must stay high, with stable attributes, until
// gnt; rvalid carries exactly one response per accepted transfer, in order,
// no earlier than the cycle after acceptance.

module ipr_rw_arbiter
    import ipr_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = IPR_MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic [3:0]  rd_be,
    input  logic        rd_we,
    output logic        rd_gnt,
    output logic        rd_rvalid,
    output logic [31:0] rd_rdata,

    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_wdata,
    input  logic [3:0]  wr_be,
    input  logic        wr_we,
    output logic        wr_gnt,
    output logic        wr_rvalid,
    output logic [31:0] wr_rdata,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,

    output logic        err
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    // Arbitration state
    ipr_port_e prio_q, prio_d;
    logic      lock_q, lock_d;
    ipr_port_e lock_sel_q, lock_sel_d;

    // Per-cycle decisions
    ipr_port_e sel;
    logic      sel_req;
    logic      full;
    logic      accept;
    logic      pop;

    // ID FIFO interface
    ipr_port_e     fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;

    // The per-port we inputs carry no information: direction is fixed by port.
    logic unused_inputs;
    assign unused_inputs = ^{rd_we, wr_we, fifo_full};

    // Full uses registered occupancy only; a pop this cycle does not free a slot.
    assign full = (fifo_cnt == CW'(MAX_OUTSTANDING));

    always_comb begin
        sel = prio_q;
        if (lock_q) begin
            sel = lock_sel_q;
        end else if (rd_req && !wr_req) begin
            sel = PORT_RD;
        end else if (wr_req && !rd_req) begin
            sel = PORT_WR;
        end
    end

    assign sel_req = (sel == PORT_WR) ? wr_req : rd_req;
    assign mem_req = sel_req & ~full & ~rst;
    assign accept  = mem_req & mem_gnt;

    assign rd_gnt = accept & (sel == PORT_RD);
    assign wr_gnt = accept & (sel == PORT_WR);

    assign mem_addr  = (sel == PORT_WR) ? wr_addr  : rd_addr;
    assign mem_be    = (sel == PORT_WR) ? wr_be    : rd_be;
    assign mem_wdata = (sel == PORT_WR) ? wr_wdata : 32'h0;
    assign mem_we    = (sel == PORT_WR);

    // Response routing: owner comes from the registered FIFO head.
    assign pop       = mem_rvalid & ~fifo_empty & ~rst;
    assign rd_rvalid = pop & (fifo_head == PORT_RD);
    assign wr_rvalid = pop & (fifo_head == PORT_WR);
    assign rd_rdata  = mem_rdata;
    assign wr_rdata  = mem_rdata;
    assign err       = mem_rvalid & fifo_empty & ~rst;

    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;

        if (accept) begin
            prio_d = other_port(sel);
        end

        // While locked, sel is the locked port, so ~sel_req means it withdrew
        // its request; that is the only way out of a lock besides a grant.
        if (lock_q && !sel_req) begin
            lock_d = 1'b0;
        end else if (accept) begin
            lock_d = 1'b0;
        end else if (mem_req && !mem_gnt) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= PORT_RD;
            lock_q     <= 1'b0;
            lock_sel_q <= PORT_RD;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    ipr_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (sel),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .cnt     (fifo_cnt)
    );

endmodule

// File: tb/tb_ipr_rw_arbiter.sv
// tb_ipr_rw_arbiter
// Directed and randomized checks of ipr_rw_arbiter against a reference model
// built from the arbitration rules: a queue of owners for outstanding
// transfers, a round-robin preference bit and a "held request" marker.

module tb_ipr_rw_arbiter;

    localparam int MAX = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic        rd_req, rd_we, rd_gnt, rd_rvalid;
    logic [31:0] rd_addr, rd_rdata;
    logic [3:0]  rd_be;
    logic        wr_req, wr_we, wr_gnt, wr_rvalid;
    logic [31:0] wr_addr, wr_wdata, wr_rdata;
    logic [3:0]  wr_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    ipr_rw_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_be      (rd_be),
        .rd_we      (rd_we),
        .rd_gnt     (rd_gnt),
        .rd_rvalid  (rd_rvalid),
        .rd_rdata   (rd_rdata),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_wdata   (wr_wdata),
        .wr_be      (wr_be),
        .wr_we      (wr_we),
        .wr_gnt     (wr_gnt),
        .wr_rvalid  (wr_rvalid),
        .wr_rdata   (wr_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: owners of outstanding transfers (0 = rd, 1 = wr)
    bit m_q[$];
    bit m_prio     = 1'b0;  // port preferred when both ask
    bit m_lock     = 1'b0;  // a request was offered and not yet granted
    bit m_lock_sel = 1'b0;

    // Expectations for the current cycle
    bit e_sel, e_req, e_acc, e_pop, e_own;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_req     = 1'b0;
        wr_req     = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    // Waits to the falling edge and compares every output with the model.
    task automatic check_cycle();
        @(negedge clk);
        if (rst) begin
            e_req = 1'b0;
            e_acc = 1'b0;
            e_pop = 1'b0;
            chk1("rst_mem_req",   mem_req,   1'b0);
            chk1("rst_rd_gnt",    rd_gnt,    1'b0);
            chk1("rst_wr_gnt",    wr_gnt,    1'b0);
            chk1("rst_rd_rvalid", rd_rvalid, 1'b0);
            chk1("rst_wr_rvalid", wr_rvalid, 1'b0);
            chk1("rst_err",       err,       1'b0);
        end else begin
            if (m_lock)                e_sel = m_lock_sel;
            else if (rd_req && !wr_req) e_sel = 1'b0;
            else if (wr_req && !rd_req) e_sel = 1'b1;
            else                        e_sel = m_prio;
            e_req = (e_sel ? wr_req : rd_req) && (m_q.size() < MAX);
            e_acc = e_req && mem_gnt;
            e_pop = mem_rvalid && (m_q.size() > 0);
            e_own = e_pop ? m_q[0] : 1'b0;
            chk1("mem_req",   mem_req,   e_req);
            chk1("rd_gnt",    rd_gnt,    e_acc && !e_sel);
            chk1("wr_gnt",    wr_gnt,    e_acc && e_sel);
            if (e_req) begin
                chk32("mem_addr",  mem_addr,  e_sel ? wr_addr : rd_addr);
                chk32("mem_wdata", mem_wdata, e_sel ? wr_wdata : 32'h0);
                chk32("mem_be",    {28'h0, mem_be}, {28'h0, (e_sel ? wr_be : rd_be)});
                chk1("mem_we",     mem_we,    e_sel);
            end
            chk1("rd_rvalid", rd_rvalid, e_pop && !e_own);
            chk1("wr_rvalid", wr_rvalid, e_pop && e_own);
            chk1("err",       err,       mem_rvalid && (m_q.size() == 0));
            chk32("rd_rdata", rd_rdata,  mem_rdata);
            chk32("wr_rdata", wr_rdata,  mem_rdata);
        end
    endtask

    // Applies this cycle's outcome to the model, then moves past the edge.
    task automatic advance();
        if (rst) begin
            m_q.delete();
            m_prio     = 1'b0;
            m_lock     = 1'b0;
            m_lock_sel = 1'b0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_lock && !(m_lock_sel ? wr_req : rd_req)) begin
                m_lock = 1'b0;
            end else if (e_acc) begin
                m_lock = 1'b0;
            end else if (e_req && !mem_gnt) begin
                m_lock     = 1'b1;
                m_lock_sel = e_sel;
            end
            if (e_acc) begin
                m_q.push_back(e_sel);
                m_prio = !e_sel;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        check_cycle();
        advance();
    endtask

    bit rd_won, wr_won;

    initial begin
        rst       = 1'b1;
        idle();
        rd_addr   = 32'h0; rd_be = 4'hf; rd_we = 1'b0;
        wr_addr   = 32'h0; wr_wdata = 32'h0; wr_be = 4'hf; wr_we = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        // Reset: outputs forced low even with requests and a response present
        rd_req = 1'b1; wr_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step();
        step();
        idle();
        rst = 1'b0;
        step();

        // Stray response with nothing outstanding
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        check_cycle();
        chk1("stray_err",       err,       1'b1);
        chk1("stray_rd_rvalid", rd_rvalid, 1'b0);
        chk1("stray_wr_rvalid", wr_rvalid, 1'b0);
        advance();
        mem_rvalid = 1'b0;
        check_cycle();
        chk1("stray_err_pulse", err, 1'b0);
        advance();

        // Single read
        rd_req = 1'b1; rd_addr = 32'h100; rd_be = 4'hf; rd_we = 1'b1; mem_gnt = 1'b1;
        check_cycle();
        chk1("single_rd_gnt",    rd_gnt,   1'b1);
        chk1("single_mem_we",    mem_we,   1'b0);
        chk32("single_mem_addr", mem_addr, 32'h100);
        advance();
        idle();
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        check_cycle();
        chk1("single_rd_rvalid", rd_rvalid, 1'b1);
        chk32("single_rd_rdata", rd_rdata,  32'hDEAD_BEEF);
        chk1("single_wr_rvalid", wr_rvalid, 1'b0);
        advance();
        idle();

        // Round-robin with both ports requesting
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_req = 1'b1; wr_req = 1'b1; mem_gnt = 1'b1;
        rd_addr = 32'h200; wr_addr = 32'h280; wr_wdata = 32'hCAFE_0001; wr_be = 4'h3;
        for (int i = 0; i < 4; i++) begin
            check_cycle();
            chk1("rr_rd_gnt", rd_gnt, (i % 2) == 0);
            chk1("rr_wr_gnt", wr_gnt, (i % 2) == 1);
            advance();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            check_cycle();
            chk1("rr_rd_rvalid", rd_rvalid, (i % 2) == 0);
            chk1("rr_wr_rvalid", wr_rvalid, (i % 2) == 1);
            advance();
        end
        idle();

        // Lock: write offered but not granted keeps the bus
        wr_req = 1'b1; wr_addr = 32'h2000; wr_wdata = 32'h5555_AAAA; mem_gnt = 1'b0;
        rd_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) rd_req = 1'b1;
            check_cycle();
            chk32("lock_mem_addr", mem_addr, 32'h2000);
            chk1("lock_mem_we",    mem_we,   1'b1);
            chk1("lock_rd_gnt",    rd_gnt,   1'b0);
            advance();
        end
        mem_gnt = 1'b1;
        check_cycle();
        chk1("lock_wr_gnt",      wr_gnt,   1'b1);
        chk1("lock_rd_gnt_held", rd_gnt,   1'b0);
        chk32("lock_grant_addr", mem_addr, 32'h2000);
        advance();
        wr_req = 1'b0;
        check_cycle();
        chk1("lock_rd_next", rd_gnt, 1'b1);
        chk32("lock_rd_addr", mem_addr, 32'h300);
        advance();
        idle();
        mem_rvalid = 1'b1;
        check_cycle();
        chk1("lock_resp_wr", wr_rvalid, 1'b1);
        advance();
        check_cycle();
        chk1("lock_resp_rd", rd_rvalid, 1'b1);
        advance();
        idle();

        // Full: four reads outstanding block the fifth
        rd_req = 1'b1; mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 32'h400 + 32'(i * 4);
            check_cycle();
            chk1("fill_rd_gnt", rd_gnt, 1'b1);
            advance();
        end
        rd_addr = 32'h500;
        check_cycle();
        chk1("full_mem_req", mem_req, 1'b0);
        chk1("full_rd_gnt",  rd_gnt,  1'b0);
        advance();
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
        check_cycle();
        chk1("full_pop_mem_req", mem_req,   1'b0);
        chk1("full_pop_rd_gnt",  rd_gnt,    1'b0);
        chk1("full_pop_rvalid",  rd_rvalid, 1'b1);
        advance();
        mem_rvalid = 1'b0;
        check_cycle();
        chk1("after_full_mem_req", mem_req, 1'b1);
        chk1("after_full_rd_gnt",  rd_gnt,  1'b1);
        advance();
        idle();
        mem_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        idle();

        // Reset with two transactions outstanding
        rd_req = 1'b1; mem_gnt = 1'b1;
        step();
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        check_cycle();
        chk1("post_rst_err",       err,       1'b1);
        chk1("post_rst_rd_rvalid", rd_rvalid, 1'b0);
        advance();
        idle();

        // Randomized traffic; requesters hold until granted
        rd_won = 1'b0;
        wr_won = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(rd_req && !rd_won)) begin
                rd_req  = ($urandom_range(0, 3) != 0);
                rd_addr = $urandom;
                rd_be   = 4'($urandom);
                rd_we   = 1'($urandom);
            end
            if (!(wr_req && !wr_won)) begin
                wr_req   = ($urandom_range(0, 3) != 0);
                wr_addr  = $urandom;
                wr_wdata = $urandom;
                wr_be    = 4'($urandom);
                wr_we    = 1'($urandom);
            end
            mem_gnt = ($urandom_range(0, 2) != 0);
            if (m_q.size() > 0) mem_rvalid = ($urandom_range(0, 1) != 0);
            else                mem_rvalid = ($urandom_range(0, 15) == 0);
            mem_rdata = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            check_cycle();
            rd_won = e_acc && !e_sel;
            wr_won = e_acc && e_sel;
            advance();
        end
        rst = 1'b0;
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
